mealy_scan_ctrl: RTL
====================

// Module: mealy_scan_ctrl
// PURPOSE
// - Sequencer for the 1-bit Mealy pattern detector (11011, overlapping; match flagged combinationally on the 5th bit).
// - Accepts W-bit words on a valid/ready handshake, serialises them MSB-first into the detector and counts matches.
// - Raises a sticky threshold interrupt. The detector instance sits outside this block.
// - Only this block drives the detector's data and reset inputs.
// PARAMETERS
// - W      8  word width in bits, >= 2
// - CNT_W  8  width of match counter and threshold
// PORTS
// - clk          in   1      single clock, rising edge
// - rst          in   1      asynchronous, active-low reset (0 = reset)
// - scan_en      in   1      1 = accept words; 0 = finish current word, then idle
// - word_in      in   W      word to scan
// - word_valid   in   1      word_in valid
// - word_ready   out  1      word accepted when word_valid && word_ready at a rising edge
// - det_bit      out  1      serial bit to detector data_in
// - det_rst      out  1      drives detector's synchronous reset (1 = hold detector in S0)
// - det_match    in   1      detector data_out, Mealy, valid in the same cycle as det_bit
// - busy         out  1      1 while in SHIFT
// - cfg_thresh   in   CNT_W  irq threshold; 0 disables irq
// - match_cnt    out  CNT_W  matches since reset/cnt_clr, saturating at 2^CNT_W-1
// - cnt_clr      in   1      synchronous clear of match_cnt
// - irq          out  1      sticky, set when match_cnt reaches cfg_thresh
// - irq_clr      in   1      synchronous clear of irq
// BEHAVIOUR
// - Reset values: FSM=IDLE, shreg=0, bit_cnt=0, match_cnt=0, irq=0. Outputs: det_bit=0, det_rst=1, word_ready=0, busy=0.
// - FSM, IDLE:
//   - det_rst=1, det_bit=0.
//   - word_ready=scan_en.
//   - On accept: load shreg=word_in, bit_cnt=W-1, go to SHIFT.
// - FSM, SHIFT:
//   - det_rst=0, det_bit=shreg[W-1], busy=1.
//   - Each edge: shift shreg left by 1, bit_cnt-1.
// - Last bit (bit_cnt==0):
//   - word_ready=scan_en.
//   - If a word is accepted: reload shreg and bit_cnt, stay in SHIFT.
//   - No bubble in this case; detector state carries across the word boundary.
//   - Otherwise go to IDLE. Detector is then reset, so a pattern never spans an idle gap.
// - Latency: word accepted at edge T; its bit i (MSB=0) is on det_bit in cycle T+1+i. Its last bit is in cycle T+W.
// - Back-to-back words: one bit per clock, 100% duty.
// - Counting:
//   - In SHIFT, when det_match=1, match_cnt increments at the next edge, saturating.
//   - det_match is ignored in IDLE.
// - irq:
//   - Set at the edge where match_cnt takes a value equal to cfg_thresh (cfg_thresh!=0).
//   - Held until irq_clr. irq_clr and a set in the same cycle: set wins.
// - cnt_clr together with det_match in the same cycle: cnt_clr wins, match_cnt=0.
// - scan_en falling mid-word: the current word completes, then FSM goes to IDLE. No word is dropped or truncated.
// - word_valid without word_ready: word_in is held by the source, untouched here.
// - Reset mid-word: immediate return to reset values. Partial word discarded, det_rst=1.
// CONFIGURATION
// - SCAN_MATCH_POS_EN defined:
//   - Adds output first_pos [15:0] = {word_idx[15-$clog2(W):0], bit_idx}.
//   - Captures the position of the first match since reset/cnt_clr. Later matches do not update it.
//   - word_idx counts accepted words (wraps). bit_idx = MSB-first index of the matching bit.
//   - Adds output pos_valid, set on capture and cleared by cnt_clr.
// - SCAN_MATCH_POS_EN undefined: no first_pos/pos_valid ports and no position logic.
// TESTING
// - Reset check: rst=0 mid-stream -> det_rst=1, word_ready=0, busy=0, match_cnt=0, irq=0 immediately.
// - Word 8'b11011011 alone:
//   - Expect det_match in the bit-4 and bit-7 cycles.
//   - Expect match_cnt=2, then IDLE with det_rst=1.
// - Back-to-back 8'h03 then 8'h60 -> one match in the bit-2 cycle of the second word; match_cnt=1.
// - 8'h03, one idle cycle, then 8'h60 -> match_cnt=0.
// - cfg_thresh=3, feed 8'hDB, 8'h1B:
//   - irq rises on the edge where match_cnt becomes 3.
//   - irq_clr pulsed in the same cycle as a set keeps irq=1; irq_clr alone clears it.
// - scan_en dropped at bit 3 of a word -> all 8 bits shifted, word_ready stays 0, FSM returns to IDLE.
// - With SCAN_MATCH_POS_EN: word 1 = 8'h00, word 2 = 8'hD8 -> first_pos word_idx=1, bit_idx=4, pos_valid=1.

Source files
------------

// File: rtl/mealy_scan_ctrl.sv
// Serialises valid/ready words MSB-first into an external 11011 Mealy detector, counts matches, raises a sticky irq.
// Optional first-match position capture (first_pos/pos_valid) is built when SCAN_MATCH_POS_EN is defined.
module mealy_scan_ctrl #(
  parameter int W     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic [W-1:0]     word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             det_bit,
  output logic             det_rst,
  input  logic             det_match,
  output logic             busy,
  input  logic [CNT_W-1:0] cfg_thresh,
  output logic [CNT_W-1:0] match_cnt,
  input  logic             cnt_clr,
  output logic             irq,
  input  logic             irq_clr
`ifdef SCAN_MATCH_POS_EN
  ,
  output logic [15:0]      first_pos,
  output logic             pos_valid
`endif
);

  localparam int BC_W = $clog2(W);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [W-1:0]     shreg;
  logic [BC_W-1:0]  bit_cnt;
  logic             last_bit;
  logic             accept;
  logic             cnt_inc;
  logic             irq_set;

  assign last_bit = (bit_cnt == '0);
  assign accept   = word_valid && word_ready;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SHIFT;
      SHIFT:   if (last_bit && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    det_rst    = 1'b1;
    det_bit    = 1'b0;
    busy       = 1'b0;
    word_ready = 1'b0;
    case (state)
      IDLE: begin
        // Gated by rst so word_ready reads 0 the instant reset asserts.
        word_ready = scan_en && rst;
      end
      SHIFT: begin
        det_rst    = 1'b0;
        det_bit    = shreg[W-1];
        busy       = 1'b1;
        word_ready = scan_en && last_bit;
      end
      default: ;
    endcase
  end

  // A reload on the last bit keeps the stream gap-free across word boundaries.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shreg   <= word_in;
      bit_cnt <= BC_W'(W - 1);
    end else if (state == SHIFT) begin
      shreg <= {shreg[W-2:0], 1'b0};
      if (!last_bit) bit_cnt <= bit_cnt - 1'b1;
    end
  end

  assign cnt_inc = (state == SHIFT) && det_match && (match_cnt != '1);
  assign irq_set = cnt_inc && !cnt_clr && (cfg_thresh != '0) &&
                   ((match_cnt + CNT_W'(1)) == cfg_thresh);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (cnt_clr)      match_cnt <= '0;
      else if (cnt_inc) match_cnt <= match_cnt + CNT_W'(1);
      if (irq_set)      irq <= 1'b1;
      else if (irq_clr) irq <= 1'b0;
    end
  end

`ifdef SCAN_MATCH_POS_EN
  localparam int WI_W = 16 - BC_W;

  logic [WI_W-1:0] word_cnt;
  logic [WI_W-1:0] cur_word;
  logic [BC_W-1:0] bit_idx;

  assign bit_idx = BC_W'(W - 1) - bit_cnt;

  // cur_word tags the word now shifting; word_cnt already points at the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt  <= '0;
      cur_word  <= '0;
      first_pos <= '0;
      pos_valid <= 1'b0;
    end else begin
      if (accept) begin
        cur_word <= word_cnt;
        word_cnt <= word_cnt + 1'b1;
      end
      if (cnt_clr) begin
        pos_valid <= 1'b0;
      end else if ((state == SHIFT) && det_match && !pos_valid) begin
        first_pos <= {cur_word, bit_idx};
        pos_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
